// File: rtl/reset_sequencer_pkg.sv
// Shared types and default constants for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_CH         = 4;
  localparam int unsigned DEF_HOLD_CYCLES    = 5;
  localparam int unsigned DEF_STAGGER_CYCLES = 1;
  localparam int unsigned DEF_WDT_TIMEOUT    = 350;
  localparam int unsigned DEF_CNT_W          = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_wdt.sv
// RUN-state watchdog: counts edges in RUN, cleared by a kick; flags expiry
// on the edge that completes WDT_TIMEOUT kick-free edges.
module reset_sequencer_wdt
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned WDT_TIMEOUT = DEF_WDT_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_TIMEOUT - 1);

  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  assign expire_o = run_i && !kick_i && (wcnt_q == WDT_LAST);

  // Next watchdog count: cleared outside RUN, on kick or expiry; saturates.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!run_i || kick_i || expire_o) begin
      wcnt_d = '0;
    end else if (wcnt_q != '1) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all channels in reset, then releases them in index
// order with a programmable stagger. Optional RUN-state watchdog enabled by
// defining RESET_SEQUENCER_WDT_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int unsigned WDT_TIMEOUT    = DEF_WDT_TIMEOUT,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_reset,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] ch_reset_n,
  output logic              all_released,
  output logic              busy,
  output logic              wdt_fired
);

  localparam int unsigned MAX_CNT = max3(HOLD_CYCLES, STAGGER_CYCLES, WDT_TIMEOUT);

  if ($clog2(MAX_CNT + 1) > CNT_W) begin : g_cnt_w_check
    $error("reset_sequencer: CNT_W too narrow for HOLD/STAGGER/WDT counts");
  end
  if (NUM_CH < 1 || NUM_CH > 8 || HOLD_CYCLES < 1 || WDT_TIMEOUT < 2) begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST =
    CNT_W'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] ch_q, ch_d, ch_shift;
  logic              busy_q, busy_d;
  logic              all_q, all_d;
  logic              wdt_expire;

  // Channels form a thermometer code, so releasing the next one is a shift-in of 1.
  assign ch_shift = NUM_CH'({ch_q, 1'b1});

`ifdef RESET_SEQUENCER_WDT_EN
  logic wdt_fired_q;

  reset_sequencer_wdt #(
    .WDT_TIMEOUT (WDT_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wdt (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == RUN),
    .kick_i   (wdt_kick),
    .expire_o (wdt_expire)
  );

  // Sticky watchdog flag; a simultaneous req_reset suppresses it.
  always_ff @(posedge clk) begin
    if (reset)                        wdt_fired_q <= 1'b0;
    else if (wdt_expire && !req_reset) wdt_fired_q <= 1'b1;
  end

  assign wdt_fired = wdt_fired_q;
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_expire      = 1'b0;
  assign wdt_fired       = 1'b0;
`endif

  // Next-state, counter and channel logic; re-sequence overrides everything.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    unique case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (STAGGER_CYCLES == 0) begin
            ch_d    = '1;
            state_d = RUN;
          end else begin
            ch_d    = ch_shift;
            state_d = (ch_shift == '1) ? RUN : RELEASE;
          end
        end
      end
      RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d   = '0;
          ch_d    = ch_shift;
          state_d = (ch_shift == '1) ? RUN : RELEASE;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        ch_d    = '0;
      end
    endcase
    if (req_reset || wdt_expire) begin
      state_d = HOLD;
      cnt_d   = '0;
      ch_d    = '0;
    end
    busy_d = (state_d != RUN);
    all_d  = (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b1;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      all_q   <= all_d;
    end
  end

  assign ch_reset_n   = ch_q;
  assign all_released = all_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, zero-stagger and short-watchdog
// instances driven from one linear stimulus sequence.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic kick_a = 1'b0, kick_b = 1'b0, kick_c = 1'b0;

  logic [3:0] ch_a, ch_b, ch_c;
  logic       all_a, all_b, all_c;
  logic       busy_a, busy_b, busy_c;
  logic       wdt_a, wdt_b, wdt_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reset_sequencer u_a (
    .clk(clk), .reset(reset), .req_reset(req_a), .wdt_kick(kick_a),
    .ch_reset_n(ch_a), .all_released(all_a), .busy(busy_a), .wdt_fired(wdt_a)
  );

  reset_sequencer #(.HOLD_CYCLES(3), .STAGGER_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .req_reset(req_b), .wdt_kick(kick_b),
    .ch_reset_n(ch_b), .all_released(all_b), .busy(busy_b), .wdt_fired(wdt_b)
  );

  reset_sequencer #(.WDT_TIMEOUT(10)) u_c (
    .clk(clk), .reset(reset), .req_reset(req_c), .wdt_kick(kick_c),
    .ch_reset_n(ch_c), .all_released(all_c), .busy(busy_c), .wdt_fired(wdt_c)
  );

  // Expected channel vector for hold 5 / stagger 1, d edges after sequence start.
  function automatic logic [3:0] thermo(input int d);
    int k;
    if (d < 5) return 4'h0;
    k = d - 4;
    if (k > 4) k = 4;
    case (k)
      1:       return 4'h1;
      2:       return 4'h3;
      3:       return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string name, input int e,
                           input logic [3:0] ch, input logic all, input logic bsy,
                           input logic wdt, input logic [3:0] ch_exp, input logic wdt_exp);
    check($sformatf("%s.ch@%0d", name, e), 32'(ch), 32'(ch_exp));
    check($sformatf("%s.all@%0d", name, e), 32'(all), 32'(ch_exp == 4'hF));
    check($sformatf("%s.busy@%0d", name, e), 32'(bsy), 32'(ch_exp != 4'hF));
    check($sformatf("%s.wdt@%0d", name, e), 32'(wdt), 32'(wdt_exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    check_dut("A.rst", 0, ch_a, all_a, busy_a, wdt_a, 4'h0, 1'b0);
    check_dut("B.rst", 0, ch_b, all_b, busy_b, wdt_b, 4'h0, 1'b0);
    check_dut("C.rst", 0, ch_c, all_c, busy_c, wdt_c, 4'h0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_c;
    logic       wexp_c;

    // Power-on sequence; C runs with no kicks.
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      step();
      check_dut("A.seq", e, ch_a, all_a, busy_a, wdt_a, thermo(e), 1'b0);
      check_dut("B.seq", e, ch_b, all_b, busy_b, wdt_b, (e >= 3) ? 4'hF : 4'h0, 1'b0);
`ifdef RESET_SEQUENCER_WDT_EN
      exp_c  = (e < 18) ? thermo(e) : thermo(e - 18);
      wexp_c = (e >= 18);
`else
      exp_c  = thermo(e);
      wexp_c = 1'b0;
`endif
      check_dut("C.wdt", e, ch_c, all_c, busy_c, wdt_c, exp_c, wexp_c);
    end

    // req_reset at edge 6 re-asserts released channels and restarts the count.
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      req_a = (e == 6);
      step();
      check_dut("A.req", e, ch_a, all_a, busy_a, wdt_a,
                (e < 6) ? thermo(e) : thermo(e - 6), 1'b0);
    end
    req_a = 1'b0;

    // Regular kicks every 9 edges keep C in RUN.
    do_reset();
    for (int e = 1; e <= 350; e++) begin
      kick_c = ((e % 9) == 0);
      step();
      check_dut("C.kick", e, ch_c, all_c, busy_c, wdt_c, thermo(e), 1'b0);
    end
    kick_c = 1'b0;

    // req_reset on the would-be expiry edge wins; wdt_fired stays clear.
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      req_c = (e == 18);
      step();
      check_dut("C.tie", e, ch_c, all_c, busy_c, wdt_c,
                (e < 18) ? thermo(e) : thermo(e - 18), 1'b0);
    end
    req_c = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
